dif_radix2_64p_tm_ctrl: RTL and testbench
=========================================

Name: dif_radix2_64p_tm_ctrl

Overview:
Sequencer that drives the 64-point DIF twiddle multiplier (dif_radix2_64p_tm). It consumes the sample-valid/start-of-frame stream from the preceding butterfly stage and produces the 6-bit twiddle selector and the capture enable in the same cycle as each sample. It also tracks the multiplier's 1-cycle register latency with valid, sof and eof sidebands toward the next stage, and applies downstream backpressure to the multiplier and upstream.

Parameters:
STRICT_SOF, 1, 1: after sample 63 the block returns to IDLE and requires in_sof to start the next frame; 0: sample 0 of the next frame follows immediately, with in_sof optional.
FRAME_CNT_W, 16, width of the completed-frame counter (wraps).

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  sample present on the multiplier's din_real/din_imag
in_sof  in  1  qualifies the current sample as index 0 of a frame
in_ready  out  1  block and multiplier can accept the sample this cycle
tm64_ctrl  out  6  twiddle selector to the multiplier (combinational)
tm_en  out  1  capture enable to the multiplier's halt_ctrl (combinational)
out_valid  out  1  multiplier dout_real/dout_imag holds a valid sample
out_sof  out  1  out_valid sample is index 0
out_eof  out  1  out_valid sample is index 63
out_ready  in  1  downstream accepts the out_valid sample
frame_err  out  1  1-cycle pulse: in_sof arrived mid-frame
frame_cnt  out  FRAME_CNT_W  completed frames, wraps modulo 2^FRAME_CNT_W

Behaviour:
- Reset (rst_n=0 at posedge) clears the following: state=IDLE, idx=0, out_valid=0, out_sof=0, out_eof=0, frame_err=0, frame_cnt=0. Reset asserted mid-frame discards the partial frame and emits no eof.
- Ready and enable:
  - in_ready = !out_valid || out_ready. This is a single-stage pipeline with no skid buffer.
  - acc = in_valid && in_ready.
  - tm_en = acc && (state==RUN || in_sof).
- Effective index: eidx = in_sof ? 0 : idx.
- Selector: tm64_ctrl = {eidx[2:0], eidx[5:3]}. The upper field is the column code and the lower field is the row.
  - Examples: eidx 9 -> 6'b001001; eidx 13 -> 6'b101001; eidx 0..7 -> row 0 (unity twiddle).
- States: IDLE, RUN.
  - IDLE, acc with in_sof=0: the sample is consumed and dropped. tm_en=0, out_valid is unchanged, idx stays 0.
  - IDLE, acc with in_sof=1: the sample is processed as index 0, idx<=1, state goes to RUN.
  - RUN, acc with in_sof=1 and idx!=0: frame_err=1 for the next cycle. The sample restarts the frame as index 0, idx<=1, and frame_cnt is unchanged.
  - RUN, acc with in_sof=1 and idx==0: this is a normal start, no error.
  - RUN, acc with eidx==63: idx<=0 and frame_cnt<=frame_cnt+1. State goes to IDLE if STRICT_SOF=1, otherwise stays in RUN.
  - RUN, acc otherwise: idx<=idx+1.
  - No acc: idx and state hold.
- Output sideband (registered, latency 1, aligned with the multiplier output register):
  - On tm_en: out_valid<=1, out_sof<=(eidx==0), out_eof<=(eidx==63).
  - Else if out_ready: out_valid<=0, out_sof<=0, out_eof<=0.
  - Otherwise out_valid, out_sof and out_eof hold. tm_en=0 also freezes the multiplier register.
- Simultaneous out_ready and acc: the old sample leaves and the new sample enters in the same cycle, giving full throughput of 1 sample/clk.
- A dropped IDLE sample never raises out_valid.

Decomposition:
- Shared package dif64_pkg:
  - FFT_N=64, IDX_W=6.
  - IDLE/RUN state encoding.
  - Function tm64_sel(idx) returning {idx[2:0], idx[5:3]}; the multiplier testbench reuses it.
- No sub-module; the block is a single FSM plus counters.

Test Plan:
- Full frame, back-to-back: after reset, 64 samples with in_sof on the first and out_ready=1. Required response:
  - tm64_ctrl sequence 000000, 001000, 010000, ..., 111111 on consecutive cycles.
  - out_valid rises 1 cycle after the first accept; out_sof at sample 0, out_eof at sample 63.
  - frame_cnt=1.
- Pre-sof garbage: 5 samples with in_sof=0 in IDLE, then an sof frame. Required response: tm_en=0 and out_valid=0 for the first 5, and the frame then proceeds normally from index 0.
- Backpressure: hold out_ready=0 at sample 20. Required response:
  - in_ready=0 and tm_en=0 while out_ready is low.
  - tm64_ctrl stays 6'b100010 (eidx 20) throughout.
  - On release, resume with no loss or duplication; 64 outputs total.
- Mid-frame sof: in_sof at idx=30. Required response:
  - frame_err pulses once.
  - tm64_ctrl=000000 for that sample; out_sof on it.
  - frame_cnt is unchanged until that frame's sample 63.
- STRICT_SOF=0, two frames with no sof on the second. Required response: index wraps 63->0, eof then sof on consecutive outputs, frame_cnt=2. With STRICT_SOF=1 the second frame is dropped entirely.
- Reset at idx=40: rst_n=0 for 1 cycle. Required response: all outputs 0, state IDLE, and a following in_sof frame starts cleanly from tm64_ctrl=000000.

Source files
------------

// File: rtl/dif64_pkg.sv
// rtl/dif64_pkg.sv - shared constants, state encoding and twiddle selector for the 64-point DIF stage
package dif64_pkg;

  localparam int FFT_N = 64;
  localparam int IDX_W = 6;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Column code in the upper field, row in the lower field.
  function automatic logic [IDX_W-1:0] tm64_sel(input logic [IDX_W-1:0] idx);
    return {idx[2:0], idx[5:3]};
  endfunction

endpackage

// File: rtl/dif_radix2_64p_tm_ctrl.sv
// rtl/dif_radix2_64p_tm_ctrl.sv - sample sequencer and output sideband tracker for the 64-point twiddle multiplier
module dif_radix2_64p_tm_ctrl
  import dif64_pkg::*;
#(
  parameter bit STRICT_SOF  = 1'b1,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic                   in_sof,
  output logic                   in_ready,
  output logic [IDX_W-1:0]       tm64_ctrl,
  output logic                   tm_en,
  output logic                   out_valid,
  output logic                   out_sof,
  output logic                   out_eof,
  input  logic                   out_ready,
  output logic                   frame_err,
  output logic [FRAME_CNT_W-1:0] frame_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_N - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [IDX_W-1:0]       r_idx;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic [IDX_W-1:0]       w_eidx;
  logic                   r_out_valid;
  logic                   r_out_sof;
  logic                   r_out_eof;
  logic                   r_frame_err;
  logic [FRAME_CNT_W-1:0] r_frame_cnt;
  logic                   w_acc;
  logic                   w_en;
  logic                   w_sof_err;
  logic                   w_frame_done;

  // Single output register, no skid: a new sample enters only as the old one leaves.
  assign in_ready  = !r_out_valid || out_ready;
  assign w_acc     = in_valid && in_ready;
  assign w_eidx    = in_sof ? '0 : r_idx;
  assign w_en      = w_acc && (r_state == RUN || in_sof);
  assign tm64_ctrl = tm64_sel(w_eidx);
  assign tm_en     = w_en;

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_sof_err    = 1'b0;
    w_frame_done = 1'b0;
    if (w_acc) begin
      if (in_sof) begin
        w_state_nxt = RUN;
        w_idx_nxt   = IDX_W'(1);
        w_sof_err   = (r_state == RUN) && (r_idx != '0);
      end else if (r_state == RUN) begin
        if (r_idx == LAST_IDX) begin
          w_idx_nxt    = '0;
          w_frame_done = 1'b1;
          w_state_nxt  = STRICT_SOF ? IDLE : RUN;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_eof   <= 1'b0;
      r_frame_err <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      r_frame_err <= w_sof_err;
      if (w_frame_done) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
      // Sidebands track the multiplier output register, which only loads on tm_en.
      if (w_en) begin
        r_out_valid <= 1'b1;
        r_out_sof   <= (w_eidx == '0);
        r_out_eof   <= (w_eidx == LAST_IDX);
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
        r_out_sof   <= 1'b0;
        r_out_eof   <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_sof   = r_out_sof;
  assign out_eof   = r_out_eof;
  assign frame_err = r_frame_err;
  assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_dif_radix2_64p_tm_ctrl.sv
// tb/tb_dif_radix2_64p_tm_ctrl.sv - scoreboard bench for strict and non-strict sequencer instances
module tb_dif_radix2_64p_tm_ctrl;

  logic clk;
  logic rst_n;
  logic in_valid;
  logic in_sof;
  logic out_ready;

  logic        s_in_ready, s_tm_en, s_out_valid, s_out_sof, s_out_eof, s_frame_err;
  logic [5:0]  s_tm64;
  logic [15:0] s_frame_cnt;
  logic        n_in_ready, n_tm_en, n_out_valid, n_out_sof, n_out_eof, n_frame_err;
  logic [5:0]  n_tm64;
  logic [15:0] n_frame_cnt;

  int n_pass  = 0;
  int n_total = 0;
  int s_nout  = 0;
  int n_nout  = 0;
  int base;

  logic [1:0] qs[$];
  logic [1:0] qn[$];

  dif_radix2_64p_tm_ctrl #(.STRICT_SOF(1'b1), .FRAME_CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_ready(s_in_ready),
    .tm64_ctrl(s_tm64), .tm_en(s_tm_en), .out_valid(s_out_valid), .out_sof(s_out_sof),
    .out_eof(s_out_eof), .out_ready(out_ready), .frame_err(s_frame_err), .frame_cnt(s_frame_cnt)
  );

  dif_radix2_64p_tm_ctrl #(.STRICT_SOF(1'b0), .FRAME_CNT_W(16)) dut_ns (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_ready(n_in_ready),
    .tm64_ctrl(n_tm64), .tm_en(n_tm_en), .out_valid(n_out_valid), .out_sof(n_out_sof),
    .out_eof(n_out_eof), .out_ready(out_ready), .frame_err(n_frame_err), .frame_cnt(n_frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] exp_sel(input int e);
    logic [5:0] v;
    v = e[5:0];
    return {v[2:0], v[5:3]};
  endfunction

  // Scoreboard: every transfer out of either instance pops the oldest expected {sof,eof}.
  always @(negedge clk) begin
    if (rst_n) begin
      if (s_out_valid === 1'b1 && out_ready === 1'b1) begin
        s_nout++;
        n_total++;
        if (qs.size() == 0) $display("FAIL sb_strict_unexpected got sof=%b eof=%b required no output", s_out_sof, s_out_eof);
        else begin
          logic [1:0] e;
          e = qs.pop_front();
          if ({s_out_sof, s_out_eof} !== e) $display("FAIL sb_strict got %b required %b", {s_out_sof, s_out_eof}, e);
          else n_pass++;
        end
      end
      if (n_out_valid === 1'b1 && out_ready === 1'b1) begin
        n_nout++;
        n_total++;
        if (qn.size() == 0) $display("FAIL sb_loose_unexpected got sof=%b eof=%b required no output", n_out_sof, n_out_eof);
        else begin
          logic [1:0] e;
          e = qn.pop_front();
          if ({n_out_sof, n_out_eof} !== e) $display("FAIL sb_loose got %b required %b", {n_out_sof, n_out_eof}, e);
          else n_pass++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_in(input logic v, input logic s, input logic r);
    in_valid  = v;
    in_sof    = s;
    out_ready = r;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_sof = 1'b0;
    out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    qs.delete();
    qn.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (s_out_valid !== 1'b0) $display("FAIL rst_out_valid got %b required 0", s_out_valid); else n_pass++;
    n_total++; if ({s_out_sof, s_out_eof} !== 2'b00) $display("FAIL rst_sof_eof got %b required 00", {s_out_sof, s_out_eof}); else n_pass++;
    n_total++; if (s_frame_err !== 1'b0) $display("FAIL rst_frame_err got %b required 0", s_frame_err); else n_pass++;
    n_total++; if (s_frame_cnt !== 16'd0) $display("FAIL rst_frame_cnt got %0d required 0", s_frame_cnt); else n_pass++;
    n_total++; if (s_in_ready !== 1'b1) $display("FAIL rst_in_ready got %b required 1", s_in_ready); else n_pass++;
    cyc_in(1'b1, 1'b0, 1'b1);
    n_total++; if (s_tm_en !== 1'b0) $display("FAIL rst_idle_tm_en got %b required 0", s_tm_en); else n_pass++;
    n_total++; if (s_tm64 !== 6'd0) $display("FAIL rst_idle_tm64 got %b required 000000", s_tm64); else n_pass++;
    tick();
    cyc_in(1'b0, 1'b0, 1'b1);
    n_total++; if (s_out_valid !== 1'b0) $display("FAIL rst_drop_out_valid got %b required 0", s_out_valid); else n_pass++;
    tick();
  endtask

  task automatic test_full_frame();
    do_reset();
    base = s_nout;
    for (int i = 0; i < 64; i++) begin
      cyc_in(1'b1, i == 0, 1'b1);
      n_total++; if (s_tm64 !== exp_sel(i)) $display("FAIL ff_tm64 i=%0d got %b required %b", i, s_tm64, exp_sel(i)); else n_pass++;
      n_total++; if (s_tm_en !== 1'b1) $display("FAIL ff_tm_en i=%0d got %b required 1", i, s_tm_en); else n_pass++;
      if (i == 1) begin
        n_total++; if ({s_out_valid, s_out_sof} !== 2'b11) $display("FAIL ff_first_out got %b required 11", {s_out_valid, s_out_sof}); else n_pass++;
      end
      qs.push_back({i == 0, i == 63});
      qn.push_back({i == 0, i == 63});
      tick();
    end
    cyc_in(1'b0, 1'b0, 1'b1);
    n_total++; if ({s_out_valid, s_out_eof} !== 2'b11) $display("FAIL ff_last_eof got %b required 11", {s_out_valid, s_out_eof}); else n_pass++;
    tick();
    n_total++; if (s_frame_cnt !== 16'd1) $display("FAIL ff_frame_cnt got %0d required 1", s_frame_cnt); else n_pass++;
    n_total++; if (s_nout - base !== 64) $display("FAIL ff_count got %0d required 64", s_nout - base); else n_pass++;
    n_total++; if (s_out_valid !== 1'b0) $display("FAIL ff_drain got %b required 0", s_out_valid); else n_pass++;
  endtask

  task automatic test_pre_sof();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cyc_in(1'b1, 1'b0, 1'b1);
      n_total++; if ({s_tm_en, s_out_valid} !== 2'b00) $display("FAIL pre_garbage k=%0d got %b required 00", k, {s_tm_en, s_out_valid}); else n_pass++;
      tick();
    end
    for (int i = 0; i < 64; i++) begin
      cyc_in(1'b1, i == 0, 1'b1);
      n_total++; if (s_tm64 !== exp_sel(i)) $display("FAIL pre_tm64 i=%0d got %b required %b", i, s_tm64, exp_sel(i)); else n_pass++;
      qs.push_back({i == 0, i == 63});
      qn.push_back({i == 0, i == 63});
      tick();
    end
    cyc_in(1'b0, 1'b0, 1'b1);
    tick();
    n_total++; if (s_frame_cnt !== 16'd1) $display("FAIL pre_frame_cnt got %0d required 1", s_frame_cnt); else n_pass++;
    n_total++; if (qs.size() !== 0) $display("FAIL pre_pending got %0d required 0", qs.size()); else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    base = s_nout;
    for (int i = 0; i < 64; i++) begin
      if (i == 20) begin
        for (int k = 0; k < 4; k++) begin
          cyc_in(1'b1, 1'b0, 1'b0);
          n_total++; if ({s_in_ready, s_tm_en} !== 2'b00) $display("FAIL bp_stall k=%0d got %b required 00", k, {s_in_ready, s_tm_en}); else n_pass++;
          n_total++; if (s_tm64 !== 6'b100010) $display("FAIL bp_tm64 k=%0d got %b required 100010", k, s_tm64); else n_pass++;
          n_total++; if (s_out_valid !== 1'b1) $display("FAIL bp_hold k=%0d got %b required 1", k, s_out_valid); else n_pass++;
          tick();
        end
      end
      cyc_in(1'b1, i == 0, 1'b1);
      n_total++; if ({s_tm_en, s_tm64} !== {1'b1, exp_sel(i)}) $display("FAIL bp_run i=%0d got %b required %b", i, {s_tm_en, s_tm64}, {1'b1, exp_sel(i)}); else n_pass++;
      qs.push_back({i == 0, i == 63});
      qn.push_back({i == 0, i == 63});
      tick();
    end
    cyc_in(1'b0, 1'b0, 1'b1);
    tick();
    n_total++; if (s_nout - base !== 64) $display("FAIL bp_count got %0d required 64", s_nout - base); else n_pass++;
    n_total++; if (s_frame_cnt !== 16'd1) $display("FAIL bp_frame_cnt got %0d required 1", s_frame_cnt); else n_pass++;
  endtask

  task automatic test_mid_sof();
    do_reset();
    for (int i = 0; i < 94; i++) begin
      int e;
      e = (i < 30) ? i : i - 30;
      cyc_in(1'b1, (i == 0) || (i == 30), 1'b1);
      n_total++; if (s_tm64 !== exp_sel(e)) $display("FAIL mid_tm64 i=%0d got %b required %b", i, s_tm64, exp_sel(e)); else n_pass++;
      n_total++; if (s_frame_err !== (i == 31)) $display("FAIL mid_frame_err i=%0d got %b required %b", i, s_frame_err, i == 31); else n_pass++;
      if (i == 93) begin
        n_total++; if (s_frame_cnt !== 16'd0) $display("FAIL mid_cnt_before got %0d required 0", s_frame_cnt); else n_pass++;
      end
      qs.push_back({e == 0, e == 63});
      qn.push_back({e == 0, e == 63});
      tick();
    end
    cyc_in(1'b0, 1'b0, 1'b1);
    tick();
    n_total++; if (s_frame_cnt !== 16'd1) $display("FAIL mid_cnt_after got %0d required 1", s_frame_cnt); else n_pass++;
  endtask

  task automatic test_no_strict();
    do_reset();
    for (int i = 0; i < 128; i++) begin
      int e;
      e = i % 64;
      cyc_in(1'b1, i == 0, 1'b1);
      n_total++; if ({n_tm_en, n_tm64} !== {1'b1, exp_sel(e)}) $display("FAIL ns_loose i=%0d got %b required %b", i, {n_tm_en, n_tm64}, {1'b1, exp_sel(e)}); else n_pass++;
      qn.push_back({e == 0, e == 63});
      if (i < 64) begin
        qs.push_back({e == 0, e == 63});
      end else begin
        n_total++; if (s_tm_en !== 1'b0) $display("FAIL ns_strict_drop i=%0d got %b required 0", i, s_tm_en); else n_pass++;
        if (i > 64) begin
          n_total++; if (s_out_valid !== 1'b0) $display("FAIL ns_strict_valid i=%0d got %b required 0", i, s_out_valid); else n_pass++;
        end
      end
      tick();
    end
    cyc_in(1'b0, 1'b0, 1'b1);
    tick();
    n_total++; if (n_frame_cnt !== 16'd2) $display("FAIL ns_loose_cnt got %0d required 2", n_frame_cnt); else n_pass++;
    n_total++; if (s_frame_cnt !== 16'd1) $display("FAIL ns_strict_cnt got %0d required 1", s_frame_cnt); else n_pass++;
    n_total++; if (qn.size() !== 0) $display("FAIL ns_pending got %0d required 0", qn.size()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 40; i++) begin
      cyc_in(1'b1, i == 0, 1'b1);
      qs.push_back({i == 0, i == 63});
      qn.push_back({i == 0, i == 63});
      tick();
    end
    rst_n = 1'b0;
    cyc_in(1'b0, 1'b0, 1'b1);
    tick();
    rst_n = 1'b1;
    qs.delete();
    qn.delete();
    n_total++; if ({s_out_valid, s_out_sof, s_out_eof, s_frame_err} !== 4'b0000) $display("FAIL rm_outputs got %b required 0000", {s_out_valid, s_out_sof, s_out_eof, s_frame_err}); else n_pass++;
    n_total++; if (s_frame_cnt !== 16'd0) $display("FAIL rm_frame_cnt got %0d required 0", s_frame_cnt); else n_pass++;
    cyc_in(1'b1, 1'b0, 1'b1);
    n_total++; if ({s_tm_en, s_tm64} !== 7'd0) $display("FAIL rm_idle got %b required 0000000", {s_tm_en, s_tm64}); else n_pass++;
    tick();
    for (int i = 0; i < 64; i++) begin
      cyc_in(1'b1, i == 0, 1'b1);
      n_total++; if ({s_tm_en, s_tm64} !== {1'b1, exp_sel(i)}) $display("FAIL rm_frame i=%0d got %b required %b", i, {s_tm_en, s_tm64}, {1'b1, exp_sel(i)}); else n_pass++;
      qs.push_back({i == 0, i == 63});
      qn.push_back({i == 0, i == 63});
      tick();
    end
    cyc_in(1'b0, 1'b0, 1'b1);
    tick();
    n_total++; if (s_frame_cnt !== 16'd1) $display("FAIL rm_cnt_after got %0d required 1", s_frame_cnt); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_sof = 1'b0;
    out_ready = 1'b1;
    tick();
    test_reset();
    test_full_frame();
    test_pre_sof();
    test_backpressure();
    test_mid_sof();
    test_no_strict();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
